// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder: MMIO offsets, status bits, FSM states.
// The optional stats counters are enabled by defining DMEM_STATS_EN.
package dmem_pkg;

    localparam logic [3:0] OFF_LED    = 4'd0;
    localparam logic [3:0] OFF_SW     = 4'd1;
    localparam logic [3:0] OFF_TIMER  = 4'd2;
    localparam logic [3:0] OFF_CMP    = 4'd3;
    localparam logic [3:0] OFF_STATUS = 4'd4;
    localparam logic [3:0] OFF_STCNT  = 4'd5;
    localparam logic [3:0] OFF_RAMCNT = 4'd6;

    localparam int STAT_MATCH  = 0;
    localparam int STAT_DECERR = 1;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

endpackage

// File: rtl/dmem_if.sv
// Processor data-memory port: word address, store data, store enable and read data.
interface dmem_if;
    logic [31:0] address_dmem;
    logic [31:0] data;
    logic        wren;
    logic [31:0] q_dmem;

    modport master (output address_dmem, output data, output wren, input q_dmem);
    modport slave  (input address_dmem, input data, input wren, output q_dmem);
endinterface

// File: rtl/dmem_mmio.sv
// MMIO register file: LEDs, switches, timer/compare, sticky status and read mux.
// Store/RAM-write counters at offsets 5/6 exist only when DMEM_STATS_EN is defined.
module dmem_mmio
    import dmem_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        we_i,
    input  logic        store_i,
    input  logic        ram_store_i,
    input  logic        dec_err_i,
    input  logic [3:0]  off_i,
    input  logic [31:0] wdata_i,
    input  logic [15:0] switches_i,
    output logic [31:0] rdata_o,
    output logic [15:0] leds_o,
    output logic        timer_irq_o
);
    logic [15:0] leds_q, leds_d;
    logic [31:0] timer_q, timer_d;
    logic [31:0] cmp_q, cmp_d;
    logic [1:0]  status_q, status_d;
    logic [1:0]  clr_s, set_s;

    // Next-state for registers; a timer load overrides the increment, status set beats clear.
    always_comb begin
        leds_d  = leds_q;
        timer_d = timer_q + 32'd1;
        cmp_d   = cmp_q;
        clr_s   = 2'b00;
        if (we_i) begin
            case (off_i)
                OFF_LED:    leds_d  = wdata_i[15:0];
                OFF_TIMER:  timer_d = wdata_i;
                OFF_CMP:    cmp_d   = wdata_i;
                OFF_STATUS: clr_s   = wdata_i[1:0];
                default:    clr_s   = 2'b00;
            endcase
        end else begin
            clr_s = 2'b00;
        end
        set_s[STAT_MATCH]  = (timer_q == cmp_q);
        set_s[STAT_DECERR] = dec_err_i;
        status_d = (status_q & ~clr_s) | set_s;
    end

    // Register update.
    always_ff @(posedge clock) begin
        if (reset) begin
            leds_q   <= 16'h0000;
            timer_q  <= 32'h0000_0000;
            cmp_q    <= 32'hFFFF_FFFF;
            status_q <= 2'b00;
        end else begin
            leds_q   <= leds_d;
            timer_q  <= timer_d;
            cmp_q    <= cmp_d;
            status_q <= status_d;
        end
    end

`ifdef DMEM_STATS_EN
    logic [31:0] stcnt_q, ramcnt_q;

    // Stats counters; a write to a counter clears it even if that cycle is also a store.
    always_ff @(posedge clock) begin
        if (reset) begin
            stcnt_q  <= 32'h0000_0000;
            ramcnt_q <= 32'h0000_0000;
        end else begin
            if (we_i && off_i == OFF_STCNT) stcnt_q <= 32'h0000_0000;
            else if (store_i)               stcnt_q <= stcnt_q + 32'd1;
            if (we_i && off_i == OFF_RAMCNT) ramcnt_q <= 32'h0000_0000;
            else if (ram_store_i)            ramcnt_q <= ramcnt_q + 32'd1;
        end
    end
`else
    logic unused_stats_s;
    assign unused_stats_s = store_i ^ ram_store_i;
`endif

    // Combinational read mux.
    always_comb begin
        rdata_o = 32'h0000_0000;
        case (off_i)
            OFF_LED:    rdata_o = {16'h0000, leds_q};
            OFF_SW:     rdata_o = {16'h0000, switches_i};
            OFF_TIMER:  rdata_o = timer_q;
            OFF_CMP:    rdata_o = cmp_q;
            OFF_STATUS: rdata_o = {30'h0000_0000, status_q};
`ifdef DMEM_STATS_EN
            OFF_STCNT:  rdata_o = stcnt_q;
            OFF_RAMCNT: rdata_o = ramcnt_q;
`endif
            default:    rdata_o = 32'h0000_0000;
        endcase
    end

    assign leds_o      = leds_q;
    assign timer_irq_o = status_q[STAT_MATCH];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: zero-clearing RAM plus MMIO window (see dmem_mmio).
// Define DMEM_STATS_EN to add the store/RAM-write counters.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          ADDR_BITS = 12,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_FFF0
) (
    input  logic        clock,
    input  logic        reset,
    dmem_if.slave       bus,
    input  logic [15:0] switches,
    output logic [15:0] leds,
    output logic        ready,
    output logic        timer_irq
);
    localparam int DEPTH = 2 ** ADDR_BITS;

    state_e                 state_q, state_d;
    logic [ADDR_BITS-1:0]   ptr_q, ptr_d;
    logic [31:0]            mem_q [DEPTH];
    logic                   run_s, ram_hit_s, mmio_hit_s, store_s;
    logic [ADDR_BITS-1:0]   ram_idx_s;
    logic [31:0]            mmio_rdata_s, rd_s;

    assign run_s      = (state_q == ST_RUN);
    assign ram_hit_s  = ((bus.address_dmem >> ADDR_BITS) == 32'd0);
    assign mmio_hit_s = (bus.address_dmem[31:4] == MMIO_BASE[31:4]);
    assign ram_idx_s  = bus.address_dmem[ADDR_BITS-1:0];
    assign store_s    = run_s & bus.wren;

    // Clear FSM: walk every RAM index once, then enter RUN.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_CLEAR: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == {ADDR_BITS{1'b1}}) state_d = ST_RUN;
                else                            state_d = ST_CLEAR;
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_CLEAR;
        endcase
    end

    // FSM state and clear pointer.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // RAM array: cleared word-by-word in CLEAR, processor stores in RUN.
    always_ff @(posedge clock) begin
        if (!run_s)                    mem_q[ptr_q]     <= 32'h0000_0000;
        else if (store_s && ram_hit_s) mem_q[ram_idx_s] <= bus.data;
    end

    dmem_mmio u_mmio (
        .clock       (clock),
        .reset       (reset),
        .we_i        (store_s & mmio_hit_s),
        .store_i     (store_s),
        .ram_store_i (store_s & ram_hit_s),
        .dec_err_i   (store_s & ~ram_hit_s & ~mmio_hit_s),
        .off_i       (bus.address_dmem[3:0]),
        .wdata_i     (bus.data),
        .switches_i  (switches),
        .rdata_o     (mmio_rdata_s),
        .leds_o      (leds),
        .timer_irq_o (timer_irq)
    );

    // Read path; unmapped addresses and the CLEAR phase return zero.
    always_comb begin
        rd_s = 32'h0000_0000;
        if (run_s && ram_hit_s)       rd_s = mem_q[ram_idx_s];
        else if (run_s && mmio_hit_s) rd_s = mmio_rdata_s;
        else                          rd_s = 32'h0000_0000;
    end

    assign bus.q_dmem = rd_s;
    assign ready      = run_s;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the processor's data-memory port. It drives q_dmem in reply to address_dmem / data / wren.
- Word-addressed RAM backing store plus a small memory-mapped I/O (MMIO) window: LED register, switch input, free-running timer with compare, and a sticky status register.
- After reset, a clear FSM zeroes the RAM before the block accepts accesses. This guarantees deterministic memory contents for test programs.

Parameters:
- ADDR_BITS, 12, RAM index width; RAM holds 2**ADDR_BITS 32-bit words.
- MMIO_BASE, 32'hFFFF_FFF0, first word address of the 16-word MMIO window.

Ports:
- clock  in  1  master clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- address_dmem  in  32  word address from the processor.
- data  in  32  store data.
- wren  in  1  store enable for the current cycle.
- q_dmem  out  32  read data; combinational from current address and registered state.
- switches  in  16  external switch levels, readable via MMIO.
- leds  out  16  LED register value.
- ready  out  1  high once the clear sequence has completed.
- timer_irq  out  1  mirrors status bit0.

Behaviour:
- Reset values: leds=0, ready=0, timer=0, compare=32'hFFFF_FFFF, status=0, clear pointer=0, FSM=CLEAR.
- RAM contents are undefined until CLEAR finishes.
- FSM states:
  - CLEAR: writes 0 to RAM[ptr] each cycle, then ptr++. When ptr = 2**ADDR_BITS-1 is written, go to RUN next cycle. Takes exactly 2**ADDR_BITS cycles after reset deasserts.
  - RUN: ready=1; normal service.
- In CLEAR:
  - q_dmem=0.
  - Processor wren is ignored, with no side effects.
  - Timer still counts.
- Reset asserted during either state restarts CLEAR from ptr=0.
- RAM decode: address_dmem < 2**ADDR_BITS selects the RAM.
  - Read: q_dmem = RAM[addr] combinationally, same cycle.
  - Write: RAM[addr] <= data on the posedge when wren=1.
  - A read in the cycle after a write returns the new value. A same-cycle read and write to one address returns the old value.
- MMIO decode: address_dmem[31:4] == MMIO_BASE[31:4], offset = addr[3:0].
  - 0 LED: read = {16'b0, leds}; write sets leds <= data[15:0].
  - 1 SWITCH: read-only = {16'b0, switches}; writes ignored.
  - 2 TIMER: free-running counter, +1 per cycle, wraps 32'hFFFF_FFFF->0. A write loads data, and the counter increments from that value next cycle. The loaded value takes precedence over the increment in the write cycle.
  - 3 COMPARE: read/write.
  - 4 STATUS: bit0 = timer match, bit1 = decode error.
    - Both bits are sticky.
    - Write-1-to-clear using data[1:0].
    - If a set event and a clear occur in the same cycle, the set wins.
  - Other offsets read 0 (except under the optional feature).
- Timer match: sets bit0 in the cycle after timer == compare, i.e. registered on that posedge.
- Decode error: any RUN-state access that hits neither the RAM nor the MMIO window.
  - A read returns 0; a write is ignored.
  - Sets status bit1 only when wren=1. Reads have no side effects, since the address bus is valid every cycle.
- All MMIO writes commit on the posedge where wren=1; reads are combinational.

Optional Feature:
- Macro: DMEM_STATS_EN.
- When defined:
  - Offset 5 = store counter: increments per RUN-state wren=1 cycle, wraps.
  - Offset 6 = RAM-write counter: increments only for in-range RAM stores.
  - Both clear on reset; a write of any value to either counter clears it.
- When undefined: offsets 5 and 6 read 0, and no counter flops are synthesized.

Decomposition:
- Package dmem_pkg holds:
  - MMIO offset constants (OFF_LED=0, OFF_SW=1, OFF_TIMER=2, OFF_CMP=3, OFF_STATUS=4, OFF_STCNT=5, OFF_RAMCNT=6).
  - Status bit indices.
  - FSM state encoding (CLEAR=1'b0, RUN=1'b1).
- One sub-module: dmem_mmio, holding the LED, timer, compare, status and stats registers and the read mux. The RAM, clear FSM and top-level decode stay in dmem_responder.

Test Plan:
- Reset, then hold with ADDR_BITS=4 -> ready=0 for exactly 16 cycles then 1. During CLEAR, a write to addr 3 is ignored and q_dmem=0; after ready, every addr reads 0.
- RUN: write 32'hDEADBEEF to addr 5 -> next cycle q_dmem=32'hDEADBEEF at addr 5. Same-cycle read of addr 5 during that write returns the old value 0.
- Write 32'h0001_ABCD to MMIO_BASE+0 -> leds=16'hABCD, readback 32'h0000_ABCD. Switches=16'h1234 -> read of MMIO_BASE+1 = 32'h0000_1234.
- Load timer with 10 and compare with 13 -> timer reads 13 three cycles later, timer_irq=1 the following cycle. Write 1 to STATUS -> irq clears; load timer 32'hFFFF_FFFF -> reads 0 one cycle later.
- Store to addr 32'h0001_0000 (unmapped) -> status=32'h2, RAM unchanged. A read of that address returns 0 and leaves status unaffected.
- With DMEM_STATS_EN: 3 RAM stores plus 1 LED store -> offset 5 reads 4, offset 6 reads 3. Writing offset 5 -> reads 0.
